// File: rtl/shift_row_seq.sv
// -----------------------------------------------------------------------------
// shift_row_seq
//   Forward AES ShiftRows engine for the encrypt datapath. A rising edge on
//   startTransition latches inputData. Rows 1..3 are then rotated left by
//   1/2/3 bytes, either one row per cycle (ROW_SERIAL=1) or all rows in a
//   single cycle (ROW_SERIAL=0). The result is presented on a registered
//   output with a ready indication.
//
//   State byte k is inputData[127-8k -: 8]. Element s[r][c] is byte r+4c.
//
// Parameters
//   ROW_SERIAL : 1 = rows 1,2,3 rotated in successive cycles, 0 = one cycle
//   DONE_LEVEL : 0 = outputReady is a 1-cycle pulse,
//                1 = outputReady held until the next accepted start
//
// Ports
//   clock           in   1    system clock, rising edge
//   resetN          in   1    asynchronous active-low reset
//   startTransition in   1    operation request (rising edge starts one op)
//   inputData       in   128  AES state to shift
//   outputData      out  128  registered ShiftRows result
//   busy            out  1    operation in progress
//   outputReady     out  1    result valid (pulse or level, see DONE_LEVEL)
//   checkError      out  1    sticky row-parity mismatch (SHIFT_ROW_CHECK_EN)
//
// Optional feature macro: SHIFT_ROW_CHECK_EN
//   Adds checkError. The per-row XOR of the accepted state is compared with
//   the per-row XOR of the result. ShiftRows only permutes bytes within a
//   row, so any difference indicates a corrupted work register.
// -----------------------------------------------------------------------------
module shift_row_seq #(
  parameter int ROW_SERIAL = 1,
  parameter int DONE_LEVEL = 0
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         startTransition,
  input  logic [127:0] inputData,
  output logic [127:0] outputData,
  output logic         busy,
  output logic         outputReady
`ifdef SHIFT_ROW_CHECK_EN
  ,
  output logic         checkError
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ROW1  = 3'd1;
  localparam logic [2:0] ROW2  = 3'd2;
  localparam logic [2:0] ROW3  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] SHIFT = 3'd5;

  logic [2:0]   r_state;
  logic         r_startQ;
  logic [127:0] r_work;
  logic [127:0] r_out;
  logic         r_busy;
  logic         r_ready;
  logic         w_startEdge;

  // Rotate row r of the state left by r bytes: out[r][c] = in[r][(c+r)%4].
  function automatic logic [127:0] f_rot_row(input logic [127:0] s, input int r);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < 4; c++) begin
      o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    end
    return o;
  endfunction

`ifdef SHIFT_ROW_CHECK_EN
  logic [31:0] r_rowXor;
  logic        r_chkErr;

  // XOR of the four bytes of each row; row r lands in bits [31-8r -: 8].
  function automatic logic [31:0] f_row_xor(input logic [127:0] s);
    logic [31:0] x;
    x = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        x[31-8*r -: 8] = x[31-8*r -: 8] ^ s[127-8*(r+4*c) -: 8];
      end
    end
    return x;
  endfunction

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_rowXor <= '0;
      r_chkErr <= 1'b0;
    end else begin
      if (r_state == IDLE && w_startEdge) begin
        r_rowXor <= f_row_xor(inputData);
      end
      if (r_state == DONE && f_row_xor(r_work) != r_rowXor) begin
        r_chkErr <= 1'b1;
      end
    end
  end

  assign checkError = r_chkErr;
`endif

  // A held level must not retrigger, so only a low-to-high transition counts.
  assign w_startEdge = startTransition & ~r_startQ;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_startQ <= 1'b0;
      r_work   <= '0;
      r_out    <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_startQ <= startTransition;
      // Pulse mode: ready lives only for the cycle right after DONE.
      if (DONE_LEVEL == 0) begin
        r_ready <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          // Edges seen outside IDLE are dropped, never queued.
          if (w_startEdge) begin
            r_work  <= inputData;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= (ROW_SERIAL != 0) ? ROW1 : SHIFT;
          end
        end
        ROW1: begin
          r_work  <= f_rot_row(r_work, 1);
          r_state <= ROW2;
        end
        ROW2: begin
          r_work  <= f_rot_row(r_work, 2);
          r_state <= ROW3;
        end
        ROW3: begin
          r_work  <= f_rot_row(r_work, 3);
          r_state <= DONE;
        end
        SHIFT: begin
          r_work  <= f_rot_row(f_rot_row(f_rot_row(r_work, 1), 2), 3);
          r_state <= DONE;
        end
        DONE: begin
          r_out   <= r_work;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign outputData  = r_out;
  assign busy        = r_busy;
  assign outputReady = r_ready;

endmodule

// File: tb/tb_shift_row_seq.sv
module tb_shift_row_seq;

  logic         clock;
  logic         resetN;
  logic         a_start, b_start;
  logic [127:0] a_data, b_data;
  logic [127:0] a_out, b_out;
  logic         a_busy, b_busy, a_rdy, b_rdy;
`ifdef SHIFT_ROW_CHECK_EN
  logic         a_chk, b_chk;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] VEC1 = 128'h2baf939fcb302feb20abc063a2c792a0;
  localparam logic [127:0] EXP1 = 128'h2b30c0a0cbab929f20c793eba2af2f63;
  localparam logic [127:0] VEC2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP2 = 128'h0055aaff4499ee3388dd2277cc1166bb;

  shift_row_seq #(.ROW_SERIAL(1), .DONE_LEVEL(0)) dut (
    .clock(clock), .resetN(resetN), .startTransition(a_start),
    .inputData(a_data), .outputData(a_out), .busy(a_busy), .outputReady(a_rdy)
`ifdef SHIFT_ROW_CHECK_EN
    , .checkError(a_chk)
`endif
  );

  shift_row_seq #(.ROW_SERIAL(0), .DONE_LEVEL(1)) dut2 (
    .clock(clock), .resetN(resetN), .startTransition(b_start),
    .inputData(b_data), .outputData(b_out), .busy(b_busy), .outputReady(b_rdy)
`ifdef SHIFT_ROW_CHECK_EN
    , .checkError(b_chk)
`endif
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Reference: view the state as a 4x4 matrix of rows/columns and rotate each
  // row r left by r positions.
  function automatic logic [127:0] model_sr(input logic [127:0] s);
    logic [7:0] m [4][4];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = s[127-8*k -: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = m[r][(c + r) % 4];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic s, input logic [127:0] d);
    @(negedge clock);
    a_start = s;
    a_data  = d;
  endtask

  task automatic set_b(input logic s, input logic [127:0] d);
    @(negedge clock);
    b_start = s;
    b_data  = d;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    a_data = '0; b_data = '0;
    repeat (3) tick();
    checks++; if (a_out !== 128'd0) begin errors++; $display("FAIL reset_a_out: got %h expected 0", a_out); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy: got %b expected 0", a_busy); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL reset_a_rdy: got %b expected 0", a_rdy); end
    checks++; if (b_out !== 128'd0) begin errors++; $display("FAIL reset_b_out: got %h expected 0", b_out); end
    checks++; if (b_busy !== 1'b0 || b_rdy !== 1'b0) begin errors++; $display("FAIL reset_b_ctl: got busy=%b rdy=%b expected 0 0", b_busy, b_rdy); end
    @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic test_basic();
    logic bad;
    bad = 1'b0;
    repeat (500) begin tick(); if (a_rdy !== 1'b0 || a_busy !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL basic_idle: got activity expected idle"); end
    set_a(1'b1, VEC1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (a_busy !== 1'b1 || a_rdy !== 1'b0) begin
        errors++; $display("FAIL basic_busy_e%0d: got busy=%b rdy=%b expected 1 0", k, a_busy, a_rdy);
      end
    end
    tick();
    checks++; if (a_rdy !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL basic_done: got rdy=%b busy=%b expected 1 0", a_rdy, a_busy); end
    checks++; if (a_out !== EXP1) begin errors++; $display("FAIL basic_out: got %h expected %h", a_out, EXP1); end
    checks++; if (a_out !== model_sr(VEC1)) begin errors++; $display("FAIL basic_model: got %h expected %h", a_out, model_sr(VEC1)); end
    tick();
    checks++; if (a_rdy !== 1'b0 || a_out !== EXP1) begin errors++; $display("FAIL basic_pulse: got rdy=%b out=%h expected 0 %h", a_rdy, a_out, EXP1); end
    set_a(1'b0, '0);
    tick();
  endtask

  task automatic test_level_hold();
    logic [127:0] d1;
    int pulses;
    d1 = rnd128();
    pulses = 0;
    set_a(1'b1, d1);
    tick();
    set_a(1'b1, rnd128());
    for (int i = 0; i < 100; i++) begin tick(); if (a_rdy === 1'b1) pulses++; end
    checks++; if (pulses != 1) begin errors++; $display("FAIL level_pulses: got %0d expected 1", pulses); end
    checks++; if (a_out !== model_sr(d1)) begin errors++; $display("FAIL level_out: got %h expected %h", a_out, model_sr(d1)); end
    set_a(1'b0, '0);
    tick();
    set_a(1'b1, VEC2);
    repeat (5) tick();
    checks++; if (a_rdy !== 1'b1 || a_out !== EXP2) begin errors++; $display("FAIL retrigger_out: got rdy=%b out=%h expected 1 %h", a_rdy, a_out, EXP2); end
    set_a(1'b0, '0);
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [127:0] d1, d2;
    int pulses;
    d1 = rnd128();
    d2 = ~d1;
    pulses = 0;
    set_a(1'b1, d1);
    tick();
    set_a(1'b0, d1);
    tick();
    set_a(1'b1, d2);
    for (int i = 0; i < 15; i++) begin tick(); if (a_rdy === 1'b1) pulses++; end
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_ignore_pulses: got %0d expected 1", pulses); end
    checks++; if (a_out !== model_sr(d1)) begin errors++; $display("FAIL busy_ignore_out: got %h expected %h", a_out, model_sr(d1)); end
    set_a(1'b0, '0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      d = rnd128();
      set_a(1'b1, d);
      tick();
      checks++; if (a_busy !== 1'b1 || a_rdy !== 1'b0) begin errors++; $display("FAIL b2b_accept_%0d: got busy=%b rdy=%b expected 1 0", i, a_busy, a_rdy); end
      set_a(1'b0, rnd128());
      repeat (4) tick();
      checks++; if (a_rdy !== 1'b1 || a_out !== model_sr(d)) begin errors++; $display("FAIL b2b_out_%0d: got rdy=%b out=%h expected 1 %h", i, a_rdy, a_out, model_sr(d)); end
    end
    tick();
  endtask

  task automatic test_random();
    logic [127:0] d;
    int h;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      d = rnd128();
      h = $urandom_range(1, 3);
      set_a(1'b1, d);
      tick();
      for (int j = 1; j <= 4; j++) begin
        if (j == h) set_a(1'b0, rnd128());
        tick();
      end
      checks++; if (a_rdy !== 1'b1 || a_out !== model_sr(d)) begin errors++; $display("FAIL rand_out_%0d: got rdy=%b out=%h expected 1 %h", i, a_rdy, a_out, model_sr(d)); end
      tick();
      checks++; if (a_rdy !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL rand_after_%0d: got rdy=%b busy=%b expected 0 0", i, a_rdy, a_busy); end
    end
  endtask

  task automatic test_async_reset();
    logic bad;
    bad = 1'b0;
    set_a(1'b1, rnd128());
    tick();
    set_a(1'b0, '0);
    tick();
    tick();
    resetN = 1'b0;
    #1;
    checks++; if (a_out !== 128'd0 || a_busy !== 1'b0 || a_rdy !== 1'b0) begin errors++; $display("FAIL async_reset: got out=%h busy=%b rdy=%b expected 0 0 0", a_out, a_busy, a_rdy); end
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (a_rdy !== 1'b0 || a_busy !== 1'b0) bad = 1'b1; end
    checks++; if (bad || a_out !== 128'd0) begin errors++; $display("FAIL async_release: got out=%h activity=%b expected 0 0", a_out, bad); end
  endtask

  task automatic test_config_b();
    logic [127:0] d;
    logic bad;
    set_b(1'b1, VEC1);
    tick();
    checks++; if (b_busy !== 1'b1 || b_rdy !== 1'b0) begin errors++; $display("FAIL cfgb_e0: got busy=%b rdy=%b expected 1 0", b_busy, b_rdy); end
    set_b(1'b0, '0);
    tick();
    checks++; if (b_busy !== 1'b1 || b_rdy !== 1'b0) begin errors++; $display("FAIL cfgb_e1: got busy=%b rdy=%b expected 1 0", b_busy, b_rdy); end
    tick();
    checks++; if (b_rdy !== 1'b1 || b_busy !== 1'b0 || b_out !== EXP1) begin errors++; $display("FAIL cfgb_done: got rdy=%b busy=%b out=%h expected 1 0 %h", b_rdy, b_busy, b_out, EXP1); end
    for (int i = 0; i < 3; i++) begin
      bad = 1'b0;
      repeat (10) begin tick(); if (b_rdy !== 1'b1) bad = 1'b1; end
      checks++; if (bad) begin errors++; $display("FAIL cfgb_hold_%0d: got dropped expected held", i); end
      d = rnd128();
      set_b(1'b1, d);
      checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL cfgb_pre_accept_%0d: got %b expected 1", i, b_rdy); end
      tick();
      checks++; if (b_rdy !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL cfgb_accept_%0d: got rdy=%b busy=%b expected 0 1", i, b_rdy, b_busy); end
      set_b(1'b0, rnd128());
      tick();
      tick();
      checks++; if (b_rdy !== 1'b1 || b_out !== model_sr(d)) begin errors++; $display("FAIL cfgb_out_%0d: got rdy=%b out=%h expected 1 %h", i, b_rdy, b_out, model_sr(d)); end
    end
  endtask

`ifdef SHIFT_ROW_CHECK_EN
  task automatic test_check_error();
    logic bad;
    bad = 1'b0;
    checks++; if (a_chk !== 1'b0 || b_chk !== 1'b0) begin errors++; $display("FAIL chk_clean: got %b %b expected 0 0", a_chk, b_chk); end
    set_a(1'b1, rnd128());
    tick();
    set_a(1'b0, '0);
    tick();
    force dut.r_work = dut.r_work ^ {8'h01, 120'd0};
    #1;
    release dut.r_work;
    tick();
    tick();
    checks++; if (a_chk !== 1'b0) begin errors++; $display("FAIL chk_early: got %b expected 0", a_chk); end
    tick();
    checks++; if (a_chk !== 1'b1 || a_rdy !== 1'b1) begin errors++; $display("FAIL chk_done: got chk=%b rdy=%b expected 1 1", a_chk, a_rdy); end
    repeat (10) begin tick(); if (a_chk !== 1'b1) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL chk_sticky: got cleared expected 1"); end
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checks++; if (a_chk !== 1'b0) begin errors++; $display("FAIL chk_reset: got %b expected 0", a_chk); end
    @(negedge clock);
    resetN = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_level_hold();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_config_b();
`ifdef SHIFT_ROW_CHECK_EN
    test_check_error();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_row_seq.md
Name: shift_row_seq

Overview:
- Forward AES ShiftRows engine for the encryption datapath; the forward counterpart of inv_shift_row on the decrypt side.
- Latches a 128-bit state on a start edge, rotates rows 1..3 left by 1/2/3 bytes, then presents a registered result with a done indication.
- Sequential, handshaked block so the encrypt round controller can sequence it alongside sub_bytes and mix_columns.

Parameters:
- ROW_SERIAL, 1, 1 = one row rotated per cycle (rows 1,2,3 in successive cycles); 0 = all rows in one cycle.
- DONE_LEVEL, 0, 0 = outputReady is a 1-cycle pulse; 1 = outputReady held high until the next accepted start.

Ports:
- clock  input  1  system clock (50 MHz), all state updated on the rising edge
- resetN  input  1  asynchronous, active-low reset
- startTransition  input  1  operation request; a rising edge (sampled low→high) starts one operation
- inputData  input  128  AES state; byte k = bits [127-8k -: 8]; s[r][c] = byte[r+4c]
- outputData  output  128  registered ShiftRows result, out[r][c] = in[r][(c+r) mod 4]
- busy  output  1  high while an operation is in progress
- outputReady  output  1  result-valid indication (per DONE_LEVEL)

Behaviour:
- Reset (resetN low, async): state=IDLE, outputData=0, busy=0, outputReady=0, internal start-edge register=0; takes effect immediately, including mid-operation. The partial result is discarded.
- Start detect: startTransitionQ registered each cycle; startEdge = startTransition & ~startTransitionQ. A level held high does not retrigger. An edge while busy is ignored and not queued.
- FSM, ROW_SERIAL=1:
  - IDLE: on startEdge, latch inputData into workReg; busy=1; → ROW1.
  - ROW1: rotate row 1 left 1 byte → ROW2.
  - ROW2: rotate row 2 left 2 bytes → ROW3.
  - ROW3: rotate row 3 left 3 bytes → DONE.
  - DONE: outputData<=workReg; busy=0; outputReady=1; → IDLE.
- FSM, ROW_SERIAL=0: IDLE → SHIFT (all three rows) → DONE → IDLE.
- Latency, edge sampled at cycle 0:
  - ROW_SERIAL=1: outputData/outputReady valid after edge 4.
  - ROW_SERIAL=0: valid after edge 2.
- Row 0 is never modified. inputData is sampled only in the IDLE accept cycle; later changes have no effect on the operation in flight.
- outputData changes only in DONE and holds until the next DONE or reset.
- DONE_LEVEL=0: outputReady high for exactly the DONE→IDLE cycle. DONE_LEVEL=1: outputReady stays high until the cycle a new start is accepted, then drops.
- Back-to-back: a new edge can be accepted in the first IDLE cycle after DONE.
- Illegal or unused state encodings return to IDLE.

Optional Feature:
- Macro SHIFT_ROW_CHECK_EN.
- Defined:
  - Adds output checkError (1 bit, reset 0).
  - At accept, stores the XOR of the 4 bytes of each row (4×8 bits).
  - In DONE, recomputes the XOR on the result. Any row mismatch sets checkError=1 in the same cycle outputReady rises.
  - checkError is sticky until reset.
- Undefined: the port, check registers and logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic vector, ROW_SERIAL=1: reset, hold 500 cycles, raise startTransition with inputData=2baf939fcb302feb20abc063a2c792a0 → outputData=2b30c0a0cbab929f20c793eba2af2f63 with outputReady high 4 cycles after the edge; busy high for the intervening cycles.
- Level hold and retrigger: keep startTransition high 100 cycles → exactly one operation. Drop, then raise with inputData=00112233445566778899aabbccddeeff → outputData=0055aaff4499ee3388dd2277cc1166bb.
- Busy ignore: second edge 1 cycle after the first (busy=1), with different inputData → only the first result appears; no second outputReady.
- Async reset mid-op: assert resetN=0 in ROW2 → outputData=0, busy=0, outputReady=0 immediately. After release, no output until a new edge.
- ROW_SERIAL=0 / DONE_LEVEL=1: same basic vector → result after 2 edges; outputReady stays high until the next accepted start.
- SHIFT_ROW_CHECK_EN: force a workReg byte flip mid-operation → checkError=1 in the DONE cycle and stays 1 until reset.
